fifo_rd_ctrl: RTL and testbench

Read-side controller of the asynchronous FIFO, clocked entirely in the read domain. It brings the write domain's Gray-coded write pointer across with a two-flop synchronizer and keeps the binary and Gray read pointers. It computes empty and fill level, drives the storage read address, and presents data through a one-entry registered output stage with a valid/ready handshake. Its Gray read pointer output is the signal the write side synchronizes back into its own domain.

---
 rtl/fifo_rd_ctrl.sv | 150 +++++++++++++++
 tb/tb_fifo_rd_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_ctrl.sv
// ----------------------------------------------------------------------------
// fifo_rd_ctrl
//
// Read-side controller of an asynchronous FIFO. Every flop is clocked by r_clk.
// The Gray write pointer from the write domain passes through a two-flop
// synchronizer. The block keeps binary and Gray read pointers, derives empty
// and the fill level, drives the storage read address, and presents data
// through a one-entry registered output stage with a valid/ready handshake.
//
// Parameters
//   DEPTH      storage words (power of two, >= 2)
//   DATA_WIDTH word width
//
// Ports
//   r_clk      read-domain clock
//   rst_n      synchronous active-low reset
//   wptr       Gray write pointer from the write domain (asynchronous)
//   mem_rdata  storage read data, a combinational function of raddr
//   rd_ready   consumer accepts rd_data this cycle
//   raddr      storage read address
//   rptr       registered Gray read pointer, synchronized by the write side
//   rd_valid   rd_data holds a word
//   rd_data    registered output word
//   empty      storage holds no unread word (synchronized view)
//   rd_level   words in storage, excluding the output register (0..DEPTH)
// ----------------------------------------------------------------------------
module fifo_rd_ctrl #(
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned DATA_WIDTH = 8,
    localparam int unsigned AW        = $clog2(DEPTH)
) (
    input  logic                  r_clk,
    input  logic                  rst_n,
    input  logic [AW:0]           wptr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  rd_ready,
    output logic [AW-1:0]         raddr,
    output logic [AW:0]           rptr,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  empty,
    output logic [AW:0]           rd_level
);

    typedef enum logic {
        HOLD_EMPTY = 1'b0,
        HOLD_FULL  = 1'b1
    } state_t;

    // Synchronizer stages; wq1 is metastability-exposed and is never used
    // anywhere except as the source of wq2.
    logic [AW:0]           wq1_q, wq1_d;
    logic [AW:0]           wq2_q, wq2_d;

    // Read pointer kept in both encodings so rptr leaves the block straight
    // from a flop (no combinational glitches into the other domain).
    logic [AW:0]           rbin_q, rbin_d;
    logic [AW:0]           rptr_q, rptr_d;

    // Output stage
    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

    logic [AW:0]           wbin;
    logic [AW:0]           rbin_inc;
    logic                  pop;

    function automatic logic [AW:0] bin2gray(input logic [AW:0] b);
        return b ^ (b >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at or above it, i.e. the
    // XOR of every right-shifted copy of the Gray word.
    function automatic logic [AW:0] gray2bin(input logic [AW:0] g);
        logic [AW:0] b;
        b = '0;
        for (int unsigned i = 0; i <= AW; i++) begin
            b = b ^ (g >> i);
        end
        return b;
    endfunction

    always_comb begin
        wbin     = gray2bin(wq2_q);
        rbin_inc = rbin_q + 1'b1;

        empty    = (wq2_q == rptr_q);
        // Modulo-2^(AW+1) difference; the extra pointer bit lets a full
        // storage read as DEPTH rather than aliasing to zero.
        rd_level = wbin - rbin_q;

        rd_valid = (state_q == HOLD_FULL);
        raddr    = rbin_q[AW-1:0];
        rptr     = rptr_q;
        rd_data  = rd_data_q;

        // A pop refills the output register whenever it is free or being
        // drained this cycle, giving one word per cycle when streaming.
        pop = !empty && (!rd_valid || rd_ready);

        wq1_d     = wptr;
        wq2_d     = wq1_q;
        rbin_d    = rbin_q;
        rptr_d    = rptr_q;
        rd_data_d = rd_data_q;
        state_d   = state_q;

        if (pop) begin
            rbin_d    = rbin_inc;
            rptr_d    = bin2gray(rbin_inc);
            rd_data_d = mem_rdata;
        end

        case (state_q)
            HOLD_EMPTY: begin
                if (pop) begin
                    state_d = HOLD_FULL;
                end
            end
            HOLD_FULL: begin
                // Accepted with nothing to refill: the register drains.
                if (rd_ready && !pop) begin
                    state_d = HOLD_EMPTY;
                end
            end
            default: begin
                state_d = HOLD_EMPTY;
            end
        endcase
    end

    always_ff @(posedge r_clk) begin
        if (!rst_n) begin
            wq1_q     <= '0;
            wq2_q     <= '0;
            rbin_q    <= '0;
            rptr_q    <= '0;
            rd_data_q <= '0;
            state_q   <= HOLD_EMPTY;
        end else begin
            wq1_q     <= wq1_d;
            wq2_q     <= wq2_d;
            rbin_q    <= rbin_d;
            rptr_q    <= rptr_d;
            rd_data_q <= rd_data_d;
            state_q   <= state_d;
        end
    end

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// ----------------------------------------------------------------------------
// tb_fifo_rd_ctrl
//
// Bench for fifo_rd_ctrl (DEPTH=8, DATA_WIDTH=8). The bench plays the writer:
// it stores words into an 8-entry storage array and advances a Gray write
// pointer. A reference model tracks write/read counts as plain integers, with
// the synchronized write count delayed two edges, and predicts every output
// after every clock edge.
// ----------------------------------------------------------------------------
module tb_fifo_rd_ctrl;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned DW    = 8;
    localparam int unsigned NWORD = 2048;

    logic          clk;
    logic          rst_n;
    logic [3:0]    wptr;
    logic [DW-1:0] mem_rdata;
    logic          rd_ready;
    logic [2:0]    raddr;
    logic [3:0]    rptr;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          empty;
    logic [3:0]    rd_level;

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] words [NWORD];

    int unsigned ncmp;
    int unsigned nfail;

    // Reference model state
    int unsigned   wcnt;
    int unsigned   wq1_m;
    int unsigned   wq2_m;
    int unsigned   rc_m;
    logic          vm;
    logic [DW-1:0] dm;

    fifo_rd_ctrl #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DW)
    ) dut (
        .r_clk     (clk),
        .rst_n     (rst_n),
        .wptr      (wptr),
        .mem_rdata (mem_rdata),
        .rd_ready  (rd_ready),
        .raddr     (raddr),
        .rptr      (rptr),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .empty     (empty),
        .rd_level  (rd_level)
    );

    assign mem_rdata = mem[raddr];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [3:0] gray(input int unsigned v);
        logic [3:0] b;
        b = 4'(v % 16);
        return b ^ (b >> 1);
    endfunction

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        assert (act === exp) else begin
            nfail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, act, exp);
        end
    endtask

    // Advance the model across one rising edge using the inputs applied
    // before it.
    task automatic model_edge();
        bit do_pop;
        if (!rst_n) begin
            wq1_m = 0;
            wq2_m = 0;
            rc_m  = 0;
            vm    = 1'b0;
            dm    = '0;
        end else begin
            do_pop = (wq2_m != rc_m % 16) && (!vm || rd_ready);
            if (do_pop) begin
                dm   = words[rc_m];
                vm   = 1'b1;
                rc_m = rc_m + 1;
            end else if (vm && rd_ready) begin
                vm = 1'b0;
            end
            wq2_m = wq1_m;
            wq1_m = wcnt % 16;
        end
    endtask

    task automatic check_all();
        check("rptr",     32'(rptr),     32'(gray(rc_m)));
        check("raddr",    32'(raddr),    rc_m % 8);
        check("rd_valid", 32'(rd_valid), 32'(vm));
        check("rd_data",  32'(rd_data),  32'(dm));
        check("empty",    32'(empty),    32'(wq2_m == rc_m % 16));
        check("rd_level", 32'(rd_level), (wq2_m + 16 - rc_m % 16) % 16);
    endtask

    // One clock: model and DUT update on the edge, outputs compared 1 time
    // unit later, then return at the falling edge ready for new inputs.
    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
        @(negedge clk);
    endtask

    task automatic push(input logic [DW-1:0] d);
        mem[wcnt % DEPTH] = d;
        words[wcnt]       = d;
        wcnt              = wcnt + 1;
        wptr              = gray(wcnt);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        wcnt  = 0;
        wptr  = '0;
        cycle();
        rst_n = 1'b1;
    endtask

    initial begin
        int unsigned budget;
        ncmp  = 0;
        nfail = 0;
        wcnt  = 0;
        wq1_m = 0;
        wq2_m = 0;
        rc_m  = 0;
        vm    = 1'b0;
        dm    = '0;
        for (int i = 0; i < int'(DEPTH); i++) mem[i] = '0;
        for (int i = 0; i < int'(NWORD); i++) words[i] = '0;

        // Reset with a nonzero wptr presented
        rst_n    = 1'b0;
        rd_ready = 1'b0;
        wptr     = 4'b0101;
        @(negedge clk);
        cycle();
        cycle();
        check("rst_rptr",  32'(rptr),     0);
        check("rst_raddr", 32'(raddr),    0);
        check("rst_valid", 32'(rd_valid), 0);
        check("rst_data",  32'(rd_data),  0);
        check("rst_empty", 32'(empty),    1);
        check("rst_level", 32'(rd_level), 0);
        rst_n = 1'b1;
        wptr  = '0;
        cycle();
        check("rel_empty", 32'(empty),    1);
        check("rel_valid", 32'(rd_valid), 0);

        // Single word: visibility after N+1, pop on N+2
        push(8'hA5);
        cycle();
        check("n_empty", 32'(empty), 1);
        cycle();
        check("n1_empty", 32'(empty),    0);
        check("n1_level", 32'(rd_level), 1);
        cycle();
        check("n2_valid", 32'(rd_valid), 1);
        check("n2_data",  32'(rd_data),  32'h0000_00A5);
        check("n2_rptr",  32'(rptr),     32'b0001);
        check("n2_raddr", 32'(raddr),    1);
        check("n2_empty", 32'(empty),    1);

        // Backpressure: four words, consumer stalled
        do_reset();
        for (int i = 0; i < 4; i++) push(DW'($urandom));
        rd_ready = 1'b0;
        repeat (5) cycle();
        check("bp_level", 32'(rd_level), 3);
        check("bp_data",  32'(rd_data),  32'(words[0]));
        check("bp_raddr", 32'(raddr),    1);
        rd_ready = 1'b1;
        repeat (3) cycle();
        check("bp_last",  32'(rd_data),  32'(words[3]));
        check("bp_lastv", 32'(rd_valid), 1);
        cycle();
        check("bp_drain", 32'(rd_valid), 0);

        // Wrap: stream 20 more words, read pointer crosses 15 -> 0
        budget = 0;
        while (rc_m < 24 && budget < 80) begin
            if (wcnt < 24 && wcnt - rc_m < DEPTH) push(DW'($urandom));
            cycle();
            budget++;
        end
        check("wrap_rptr",  32'(rptr),  32'b1100);
        check("wrap_raddr", 32'(raddr), 0);

        // Full storage
        do_reset();
        rd_ready = 1'b0;
        for (int i = 0; i < 8; i++) push(DW'($urandom));
        check("full_wptr", 32'(wptr), 32'b1100);
        cycle();
        cycle();
        check("full_level", 32'(rd_level), 8);
        check("full_empty", 32'(empty),    0);
        check("full_rptr",  32'(rptr),     0);
        rd_ready = 1'b1;
        repeat (10) cycle();
        check("drain_level", 32'(rd_level), 0);
        check("drain_empty", 32'(empty),    1);
        check("drain_valid", 32'(rd_valid), 0);

        // Reset mid-stream with a word held
        do_reset();
        for (int i = 0; i < 5; i++) push(DW'($urandom));
        rd_ready = 1'b0;
        budget   = 0;
        while (rc_m < 3 && budget < 20) begin
            rd_ready = vm;
            cycle();
            budget++;
        end
        rd_ready = 1'b0;
        cycle();
        check("mid_raddr", 32'(raddr),    3);
        check("mid_valid", 32'(rd_valid), 1);
        rst_n    = 1'b0;
        rd_ready = 1'b1;
        cycle();
        check("mid_rst_valid", 32'(rd_valid), 0);
        check("mid_rst_rptr",  32'(rptr),     0);
        check("mid_rst_level", 32'(rd_level), 0);
        rst_n = 1'b1;

        // Random traffic
        for (int c = 0; c < 400; c++) begin
            int unsigned n;
            rd_ready = 1'($urandom_range(1, 0));
            n        = $urandom_range(2, 0);
            for (int unsigned k = 0; k < n; k++) begin
                if (wcnt - rc_m < DEPTH && wcnt < NWORD - 8) push(DW'($urandom));
            end
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
